// File: rtl/buffer_unload_sr.sv
// rtl/buffer_unload_sr.sv - parallel-in/serial-out unload register with load/ready handshake
// Accepts a word in IDLE, then drains one bit per enabled clock with valid/last strobes.
module buffer_unload_sr #(
  parameter int buff_len  = 4,
  parameter bit msb_first = 1'b1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [buff_len-1:0] x,
  input  logic                load,
  input  logic                en,
  output logic                ready,
  output logic                sout,
  output logic                sval,
  output logic                done,
  output logic [buff_len-1:0] q
);

  localparam int cw = $clog2(buff_len);
  localparam logic [cw-1:0] last_cnt = cw'(buff_len - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  logic [buff_len-1:0] sreg;
  logic [cw-1:0]       cnt;
  logic [buff_len-1:0] sreg_next;
  logic                out_bit;
  logic                busy;
  logic                last;

  always_comb begin
    sreg_next = '0;
    out_bit   = 1'b0;
    if (msb_first) begin
      sreg_next = {sreg[buff_len-2:0], 1'b0};
      out_bit   = sreg[buff_len-1];
    end else begin
      sreg_next = {1'b0, sreg[buff_len-1:1]};
      out_bit   = sreg[0];
    end
  end

  // Outputs decode registered state only; en is the sole input reaching sval/done.
  assign busy  = (state == SHIFT);
  assign last  = (cnt == last_cnt);
  assign ready = ~busy;
  assign sout  = busy & out_bit;
  assign sval  = busy & en;
  assign done  = busy & en & last;
  assign q     = sreg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            sreg  <= x;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            sreg <= sreg_next;
            if (last) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + cw'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sreg  <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
